// File: rtl/boot_rom_arbiter_if.sv
// Bus bundle between the CPU fetch/load ports, the boot ROM and the
// boot_rom_arbiter. The arbiter uses the slave modport. The CPU and ROM side
// uses the master modport.
//
// Handshake: a requester raises *_req_i with *_addr_i and holds both stable
// until *_gnt_o is seen high in the same cycle. A request and its grant in
// cycle N form one transfer. *_rvalid_o is high in cycle N+1 with *_rdata_o.
// There is no backpressure on the response, so the requester must take
// rvalid whenever it is high.
interface boot_rom_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              ibus_req_i;
  logic [31:0]       ibus_addr_i;
  logic              ibus_gnt_o;
  logic              ibus_rvalid_o;
  logic [DATA_W-1:0] ibus_rdata_o;

  logic              dbus_req_i;
  logic [31:0]       dbus_addr_i;
  logic              dbus_gnt_o;
  logic              dbus_rvalid_o;
  logic [DATA_W-1:0] dbus_rdata_o;

  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_q_i;

  // Debug view of the response-owner state (0 idle, 1 ibus, 2 dbus).
  logic [1:0]        rsp_state_o;

  modport slave (
    input  ibus_req_i, ibus_addr_i, dbus_req_i, dbus_addr_i, rom_q_i,
    output ibus_gnt_o, ibus_rvalid_o, ibus_rdata_o,
    output dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o,
    output rom_addr_o, rsp_state_o
  );

  modport master (
    output ibus_req_i, ibus_addr_i, dbus_req_i, dbus_addr_i, rom_q_i,
    input  ibus_gnt_o, ibus_rvalid_o, ibus_rdata_o,
    input  dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o,
    input  rom_addr_o, rsp_state_o
  );
endinterface

// File: rtl/boot_rom_arbiter.sv
// boot_rom_arbiter: shares the single sync-read boot ROM port (1-cycle
// latency) between the instruction-fetch bus (ibus) and the data bus (dbus).
// It accepts one request per cycle and returns the response one cycle later.
//
// Optional feature macro: ROM_ARB_RR_EN. When it is defined, round-robin
// arbitration on conflict replaces fixed priority. When it is undefined, dbus
// has fixed priority, and an ibus starvation counter forces an ibus grant
// after STARVE_MAX lost cycles.
module boot_rom_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  boot_rom_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    RSP_IDLE = 2'd0,
    RSP_IBUS = 2'd1,
    RSP_DBUS = 2'd2
  } rsp_state_e;

  rsp_state_e        rsp_state_q, rsp_state_d;
  logic              ibus_gnt, dbus_gnt;
  logic              ibus_wins_conflict;
  logic [ADDR_W-1:0] ibus_word, dbus_word;
  logic [ADDR_W-1:0] rom_addr, rom_addr_q;
  logic [DATA_W-1:0] ibus_rdata_q, dbus_rdata_q;

  // The ROM is word addressed. Byte-lane bits and bits above the ROM depth
  // are dropped, so an out-of-range address wraps.
  assign ibus_word = bus.ibus_addr_i[ADDR_W+1:2];
  assign dbus_word = bus.dbus_addr_i[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ibus_addr_i[31:ADDR_W+2], bus.ibus_addr_i[1:0],
                              bus.dbus_addr_i[31:ADDR_W+2], bus.dbus_addr_i[1:0]};

`ifdef ROM_ARB_RR_EN
  // 0 = ibus was granted last, 1 = dbus. The reset value favours dbus first.
  logic last_gnt_dbus_q;

  assign ibus_wins_conflict = last_gnt_dbus_q;

  // Remember the most recent grantee so the other port wins the next conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_gnt_dbus_q <= 1'b0;
    end else if (ibus_gnt) begin
      last_gnt_dbus_q <= 1'b0;
    end else if (dbus_gnt) begin
      last_gnt_dbus_q <= 1'b1;
    end
  end
`else
  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] starve_cnt_q, starve_cnt_d;

  assign ibus_wins_conflict = (starve_cnt_q == STARVE_LIM);

  // Count cycles in which ibus waits. Clear when it is served or withdraws.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.ibus_req_i && !ibus_gnt) begin
      if (starve_cnt_q >= STARVE_LIM) begin
        starve_cnt_d = STARVE_LIM;
      end else begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`endif

  // Grant decision. A lone requester always wins, and nothing is granted
  // while reset is asserted.
  always_comb begin
    ibus_gnt = 1'b0;
    dbus_gnt = 1'b0;
    if (rst_ni) begin
      if (bus.ibus_req_i && bus.dbus_req_i) begin
        ibus_gnt = ibus_wins_conflict;
        dbus_gnt = !ibus_wins_conflict;
      end else begin
        ibus_gnt = bus.ibus_req_i;
        dbus_gnt = bus.dbus_req_i;
      end
    end
  end

  // ROM address mux. Without a grant the address holds, so the ROM never
  // sees a spurious new address.
  always_comb begin
    rom_addr = rom_addr_q;
    if (ibus_gnt) begin
      rom_addr = ibus_word;
    end else if (dbus_gnt) begin
      rom_addr = dbus_word;
    end
  end

  // Hold the last granted address for idle cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rom_addr_q <= '0;
    end else if (ibus_gnt || dbus_gnt) begin
      rom_addr_q <= rom_addr;
    end
  end

  // Next response owner is whoever was granted this cycle.
  always_comb begin
    rsp_state_d = RSP_IDLE;
    if (ibus_gnt) begin
      rsp_state_d = RSP_IBUS;
    end else if (dbus_gnt) begin
      rsp_state_d = RSP_DBUS;
    end
  end

  // Owner register. Reset drops any response that is in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_state_q <= RSP_IDLE;
    end else begin
      rsp_state_q <= rsp_state_d;
    end
  end

  // Capture each port's delivered word so rdata holds while that port is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
    end else begin
      if (rsp_state_q == RSP_IBUS) ibus_rdata_q <= bus.rom_q_i;
      if (rsp_state_q == RSP_DBUS) dbus_rdata_q <= bus.rom_q_i;
    end
  end

  assign bus.ibus_gnt_o    = ibus_gnt;
  assign bus.dbus_gnt_o    = dbus_gnt;
  assign bus.rom_addr_o    = rom_addr;
  assign bus.ibus_rvalid_o = (rsp_state_q == RSP_IBUS);
  assign bus.dbus_rvalid_o = (rsp_state_q == RSP_DBUS);
  assign bus.ibus_rdata_o  = (rsp_state_q == RSP_IBUS) ? bus.rom_q_i : ibus_rdata_q;
  assign bus.dbus_rdata_o  = (rsp_state_q == RSP_DBUS) ? bus.rom_q_i : dbus_rdata_q;
  assign bus.rsp_state_o   = rsp_state_q;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// Directed bench for boot_rom_arbiter, with a behavioural sync-read ROM model.
module tb_boot_rom_arbiter;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  boot_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  boot_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  // Clock and ROM model: each word holds a recognisable tag plus its index.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
    return 32'hB007_0000 | {22'd0, a};
  endfunction

  always @(posedge clk) bus.rom_q_i <= rom_word(bus.rom_addr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr,
                       input logic dreq, input logic [31:0] daddr);
    bus.ibus_req_i  = ireq;
    bus.ibus_addr_i = iaddr;
    bus.dbus_req_i  = dreq;
    bus.dbus_addr_i = daddr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_d, prev_d, prev_valid;
    logic [ADDR_W-1:0] exp_word;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    drive(1'b1, 32'h8, 1'b1, 32'h10);

    // Reset state: no grant even while both ports request.
    #3;
    chk("rst_ibus_gnt",    32'(bus.ibus_gnt_o), 32'd0);
    chk("rst_dbus_gnt",    32'(bus.dbus_gnt_o), 32'd0);
    chk("rst_ibus_rvalid", 32'(bus.ibus_rvalid_o), 32'd0);
    chk("rst_dbus_rvalid", 32'(bus.dbus_rvalid_o), 32'd0);
    chk("rst_ibus_rdata",  bus.ibus_rdata_o, 32'd0);
    chk("rst_dbus_rdata",  bus.dbus_rdata_o, 32'd0);
    do_reset();

    // ibus alone, addresses 0x0, 0x4, 0x8 back to back.
    drive(1'b1, 32'h0, 1'b0, 32'h0); #3;
    chk("t1_gnt0",     32'(bus.ibus_gnt_o), 32'd1);
    chk("t1_addr0",    32'(bus.rom_addr_o), 32'd0);
    chk("t1_rvalid0",  32'(bus.ibus_rvalid_o), 32'd0);
    cyc();
    drive(1'b1, 32'h4, 1'b0, 32'h0); #3;
    chk("t1_gnt1",     32'(bus.ibus_gnt_o), 32'd1);
    chk("t1_addr1",    32'(bus.rom_addr_o), 32'd1);
    chk("t1_rvalid1",  32'(bus.ibus_rvalid_o), 32'd1);
    chk("t1_rdata1",   bus.ibus_rdata_o, 32'hB007_0000);
    cyc();
    drive(1'b1, 32'h8, 1'b0, 32'h0); #3;
    chk("t1_gnt2",     32'(bus.ibus_gnt_o), 32'd1);
    chk("t1_addr2",    32'(bus.rom_addr_o), 32'd2);
    chk("t1_rdata2",   bus.ibus_rdata_o, 32'hB007_0001);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 32'h0); #3;
    chk("t1_gnt_idle", 32'(bus.ibus_gnt_o), 32'd0);
    chk("t1_addr_hold",32'(bus.rom_addr_o), 32'd2);
    chk("t1_rvalid3",  32'(bus.ibus_rvalid_o), 32'd1);
    chk("t1_rdata3",   bus.ibus_rdata_o, 32'hB007_0002);
    cyc(); #3;
    chk("t1_rvalid4",  32'(bus.ibus_rvalid_o), 32'd0);
    chk("t1_rdata_hold", bus.ibus_rdata_o, 32'hB007_0002);
    chk("t1_dbus_quiet", 32'(bus.dbus_rvalid_o), 32'd0);

    // dbus alone, addr 0x10 -> word 4.
    cyc();
    drive(1'b0, 32'h0, 1'b1, 32'h10); #3;
    chk("t2_dgnt",     32'(bus.dbus_gnt_o), 32'd1);
    chk("t2_igrant",   32'(bus.ibus_gnt_o), 32'd0);
    chk("t2_addr",     32'(bus.rom_addr_o), 32'd4);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 32'h0); #3;
    chk("t2_drvalid",  32'(bus.dbus_rvalid_o), 32'd1);
    chk("t2_drdata",   bus.dbus_rdata_o, 32'hB007_0004);
    chk("t2_irvalid",  32'(bus.ibus_rvalid_o), 32'd0);
    chk("t2_irdata_hold", bus.ibus_rdata_o, 32'hB007_0002);

    // Both ports request continuously from a fresh reset.
    // ibus uses 0x20 (word 8), dbus uses 0x40 (word 16).
    cyc();
    do_reset();
    drive(1'b1, 32'h20, 1'b1, 32'h40);
    prev_valid = 1'b0;
    prev_d     = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef ROM_ARB_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = (k % 5) != 4;
`endif
      #3;
      chk($sformatf("t3_dgnt_%0d", k), 32'(bus.dbus_gnt_o), 32'(exp_d));
      chk($sformatf("t3_igrant_%0d", k), 32'(bus.ibus_gnt_o), 32'(!exp_d));
      exp_word = exp_d ? 10'd16 : 10'd8;
      chk($sformatf("t3_addr_%0d", k), 32'(bus.rom_addr_o), 32'(exp_word));
      if (prev_valid) begin
        chk($sformatf("t3_drv_%0d", k), 32'(bus.dbus_rvalid_o), 32'(prev_d));
        chk($sformatf("t3_irv_%0d", k), 32'(bus.ibus_rvalid_o), 32'(!prev_d));
        chk($sformatf("t3_rd_%0d", k), prev_d ? bus.dbus_rdata_o : bus.ibus_rdata_o,
            prev_d ? 32'hB007_0010 : 32'hB007_0008);
      end
      prev_valid = 1'b1;
      prev_d     = exp_d;
      cyc();
    end

`ifndef ROM_ARB_RR_EN
    // The starvation count clears when ibus withdraws: 3 dbus wins, one
    // cycle with ibus idle, then 4 more dbus wins are needed before ibus wins.
    for (int k = 0; k < 9; k++) begin
      drive(k != 3, 32'h20, 1'b1, 32'h40);
      exp_d = (k != 8);
      #3;
      chk($sformatf("t3b_dgnt_%0d", k), 32'(bus.dbus_gnt_o), 32'(exp_d));
      chk($sformatf("t3b_igrant_%0d", k), 32'(bus.ibus_gnt_o), 32'(!exp_d));
      cyc();
    end
`endif

    // Address wrap: 0x1000 -> word 0, and 0xFFF -> word 0x3FF.
    drive(1'b1, 32'h1000, 1'b0, 32'h0); #3;
    chk("t5_addr_wrap", 32'(bus.rom_addr_o), 32'd0);
    cyc();
    drive(1'b1, 32'hFFF, 1'b0, 32'h0); #3;
    chk("t5_rdata_wrap", bus.ibus_rdata_o, 32'hB007_0000);
    chk("t5_addr_top",   32'(bus.rom_addr_o), 32'h3FF);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 32'h0); #3;
    chk("t5_rdata_top",  bus.ibus_rdata_o, 32'hB007_03FF);

    // Reset in the cycle after a grant drops the response.
    cyc();
    drive(1'b1, 32'hC, 1'b0, 32'h0); #3;
    chk("t6_gnt", 32'(bus.ibus_gnt_o), 32'd1);
    cyc();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("t6_irv_rst", 32'(bus.ibus_rvalid_o), 32'd0);
    chk("t6_drv_rst", 32'(bus.dbus_rvalid_o), 32'd0);
    chk("t6_rdata_rst", bus.ibus_rdata_o, 32'd0);
    cyc(); #3;
    chk("t6_irv_hold", 32'(bus.ibus_rvalid_o), 32'd0);
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 32'h14, 1'b0, 32'h0); #3;
    chk("t6_gnt_after", 32'(bus.ibus_gnt_o), 32'd1);
    chk("t6_addr_after", 32'(bus.rom_addr_o), 32'd5);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 32'h0); #3;
    chk("t6_irv_after", 32'(bus.ibus_rvalid_o), 32'd1);
    chk("t6_rdata_after", bus.ibus_rdata_o, 32'hB007_0005);
    chk("t6_drv_after", 32'(bus.dbus_rvalid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
